stopwatch_ctrl: RTL

Minute:second stopwatch core that sits directly downstream of the clock generator. It consumes the generator's `clk_4Hz` and `clk_100Hz` square waves as level inputs in the main `clk` domain. The 100 Hz wave paces debounce sampling of the push-buttons; the 4 Hz wave advances a BCD MM:SS count. The BCD digit outputs feed the seven-segment scan stage.

---
 rtl/stopwatch_ctrl_pkg.sv | 46 ++++
 rtl/stopwatch_ctrl_debounce_onepulse.sv | 39 +++
 rtl/stopwatch_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the stopwatch core: FSM states, BCD digit limits and the count step.
// The optional lap feature is enabled by defining STOPWATCH_LAP_EN.
package stopwatch_ctrl_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX9 = 4'd9;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX5 = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_tens;
        logic [DIGIT_W-1:0] min_ones;
        logic [DIGIT_W-1:0] sec_tens;
        logic [DIGIT_W-1:0] sec_ones;
    } bcd_t;

    // One-second BCD step; 59:59 wraps to 00:00.
    function automatic bcd_t bcd_inc(input bcd_t c);
        bcd_t n;
        n = c;
        if (c.sec_ones != DIGIT_MAX9) begin
            n.sec_ones = c.sec_ones + 4'd1;
        end else begin
            n.sec_ones = '0;
            if (c.sec_tens != DIGIT_MAX5) begin
                n.sec_tens = c.sec_tens + 4'd1;
            end else begin
                n.sec_tens = '0;
                if (c.min_ones != DIGIT_MAX9) begin
                    n.min_ones = c.min_ones + 4'd1;
                end else begin
                    n.min_ones = '0;
                    if (c.min_tens != DIGIT_MAX5) n.min_tens = c.min_tens + 4'd1;
                    else                          n.min_tens = '0;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce_onepulse.sv
// Button conditioner: 2-flop synchronizer, shift register sampled on the debounce tick,
// and a one-clk pulse on each debounced rising edge.
module debounce_onepulse #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0]             r_sync;
    logic [DEB_SAMPLES-1:0] r_samp;
    logic                   r_deb;
    logic                   r_deb_d;
    logic                   r_press;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_samp  <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (i_tick) r_samp <= {r_samp[DEB_SAMPLES-2:0], r_sync[1]};
            // Level only moves once every stored sample agrees; mixed samples hold it.
            if (&r_samp)       r_deb <= 1'b1;
            else if (~|r_samp) r_deb <= 1'b0;
            r_deb_d <= r_deb;
            r_press <= r_deb & ~r_deb_d;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch core: tick edge detection, debounced buttons, IDLE/RUN/PAUSE FSM and BCD count.
// Define STOPWATCH_LAP_EN to add the btn_lap input and the lap-freeze display.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DEB_SAMPLES   = 4,
    parameter int TICKS_PER_SEC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clk_4Hz,
    input  logic               clk_100Hz,
    input  logic               btn_start,
    input  logic               btn_clear,
`ifdef STOPWATCH_LAP_EN
    input  logic               btn_lap,
`endif
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    logic    r_clk4_d;
    logic    r_clk100_d;
    logic    w_tick_q;
    logic    w_tick_s;
    logic    w_start_p;
    logic    w_clear_p;
    state_t  r_state;
    logic [PW-1:0] r_presc;
    bcd_t    r_cnt;
    logic    r_running;
    bcd_t    w_disp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk4_d   <= 1'b0;
            r_clk100_d <= 1'b0;
        end else begin
            r_clk4_d   <= clk_4Hz;
            r_clk100_d <= clk_100Hz;
        end
    end

    assign w_tick_q = clk_4Hz & ~r_clk4_d;
    assign w_tick_s = clk_100Hz & ~r_clk100_d;

    debounce_onepulse #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_start (
        .clk(clk), .rst_n(rst_n), .i_tick(w_tick_s), .i_btn(btn_start), .o_press(w_start_p)
    );

    debounce_onepulse #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_clear (
        .clk(clk), .rst_n(rst_n), .i_tick(w_tick_s), .i_btn(btn_clear), .o_press(w_clear_p)
    );

    // Clear outranks everything; a tick in RUN is counted even when start pauses in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
        end else if (w_clear_p) begin
            r_state   <= ST_IDLE;
            r_presc   <= '0;
            r_cnt     <= '0;
            r_running <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_tick_q) begin
                if (r_presc == PRESC_LAST) begin
                    r_presc <= '0;
                    r_cnt   <= bcd_inc(r_cnt);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
            if (w_start_p) begin
                case (r_state)
                    ST_IDLE:  begin r_state <= ST_RUN;   r_running <= 1'b1; end
                    ST_RUN:   begin r_state <= ST_PAUSE; r_running <= 1'b0; end
                    ST_PAUSE: begin r_state <= ST_RUN;   r_running <= 1'b1; end
                    default:  begin r_state <= ST_IDLE;  r_running <= 1'b0; end
                endcase
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic w_lap_p;
    bcd_t r_lap;
    logic r_frozen;

    debounce_onepulse #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb_lap (
        .clk(clk), .rst_n(rst_n), .i_tick(w_tick_s), .i_btn(btn_lap), .o_press(w_lap_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lap    <= '0;
            r_frozen <= 1'b0;
        end else if (w_clear_p) begin
            r_frozen <= 1'b0;
        end else if (w_lap_p) begin
            if (r_frozen) begin
                r_frozen <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_frozen <= 1'b1;
                r_lap    <= r_cnt;
            end
        end
    end

    assign w_disp = r_frozen ? r_lap : r_cnt;
`else
    assign w_disp = r_cnt;
`endif

    assign min_tens = w_disp.min_tens;
    assign min_ones = w_disp.min_ones;
    assign sec_tens = w_disp.sec_tens;
    assign sec_ones = w_disp.sec_ones;
    assign running  = r_running;

endmodule
